note_sequencer: RTL
===================

# note_sequencer

Upstream control stage for the single-voice synth. It debounces the raw trigger push-button and, while the button is held, steps through a fixed eight-note table. For each note it drives the oscillator frequency word (`freq`, consumed by `nco`) and a timed gate pulse (`gate`, consumed by `adsr`). It runs entirely in the audio_clock domain and replaces the constant 440 Hz frequency register and the direct key-to-gate wiring.

## Interface
- `DEBOUNCE_CYCLES`, 1920: cycles a new key level must persist before it is accepted (10 ms at 192 kHz).
- `STEP_CYCLES`, 38400: period of one sequence step, gate-on plus gate-off (200 ms).
- `GATE_CYCLES`, 28800: gate-high portion of each step (150 ms). Constraint: 1 ≤ GATE_CYCLES < STEP_CYCLES; violation is an elaboration-time error.
- `audio_clock` in 1: 192 kHz sample clock.
- `reset` in 1: reset, asynchronous, active-high.
- `key_n` in 1: raw push-button, active-low, asynchronous, bouncy.
- `gate` out 1: note gate to `adsr`.
- `freq` out `frequency`: oscillator increment to `nco`.
- `step` out 3: index of the current or last note.
- `pressed` out 1: debounced key state, 1 = held.

## Operation
- Synchroniser: two flops on `key_n`, both reset to 1 (released).
- Debouncer:
  - `stable` register resets to 1 (released).
  - Counter resets to 0; it clears whenever the synchronised level equals `stable` and increments otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, `stable` toggles and the counter clears.
  - `pressed` = ~`stable`. A bounce shorter than DEBOUNCE_CYCLES leaves `stable` unchanged.
- FSM states: IDLE, GATE_ON, GATE_OFF. Step timer width is $clog2(STEP_CYCLES).
  - IDLE: `gate` = 0; `freq` holds its last value. On a `pressed` rising edge: `step` ← 0, `freq` ← NOTE_TABLE[0], `gate` ← 1, timer ← 0, go to GATE_ON.
  - GATE_ON: timer increments each cycle.
    - If `pressed` = 0: `gate` ← 0, go to IDLE (release cuts the note immediately).
    - Else, at timer = GATE_CYCLES-1: `gate` ← 0, go to GATE_OFF.
  - GATE_OFF: timer increments each cycle.
    - If `pressed` = 0: go to IDLE.
    - Else, at timer = STEP_CYCLES-1: `step` ← (`step`+1) mod 8, `freq` ← NOTE_TABLE[next], `gate` ← 1, timer ← 0, go to GATE_ON.
- Release during GATE_ON and timer expiry in the same cycle: release wins; the next state is IDLE.
- `freq` is never cleared after a note, so the `adsr` release tail keeps its pitch.
- `step` wraps 7 → 0. A fresh press always restarts at step 0.
- Frequency encoding: `freq` = NOTE_TABLE[i] << FREQUENCY_FRACTIONAL_BITS, with integer Hz zero-extended to `frequency` width.

## Timing
- Reset values: `gate` 0, `freq` 0, `step` 0, `pressed` 0, state IDLE, all counters 0.
- All outputs are registered. Nothing is combinational from `key_n`.
- Press latency: `pressed` rises 2 + DEBOUNCE_CYCLES edges after a clean `key_n` fall; `gate` and `freq` update on the following edge.
- While held, the `gate` high time is exactly GATE_CYCLES and the gate period is exactly STEP_CYCLES.
- Release latency: `gate` falls one edge after `pressed` falls.
- Asserting `reset` mid-note forces all outputs to their reset values immediately. After `reset` deasserts, a held key is detected afresh through the full debounce.

## Structure
- Add to `mypackage`:
  - `NOTE_COUNT` = 8.
  - `NOTE_TABLE`, a constant array of integer Hz: 220, 247, 277, 294, 330, 370, 415, 440 (A major).
  - `typedef enum {IDLE, GATE_ON, GATE_OFF} seq_state`.
  - Reuse the existing `frequency` and FREQUENCY_FRACTIONAL_BITS.
- Sub-module `debounce`, parameter DEBOUNCE_CYCLES: contains the synchroniser and debouncer; inputs `key_n`, output `pressed`. The top level instantiates it.

## Test plan
Use DEBOUNCE_CYCLES=4, STEP_CYCLES=10, GATE_CYCLES=6 unless stated otherwise.
- Reset: assert `reset` with `key_n`=0 → `gate`=0, `freq`=0, `step`=0, `pressed`=0 immediately. After deassertion, `pressed` rises exactly 6 edges later.
- Bounce rejection: toggle `key_n` low for 3 cycles, high for 1, repeated 5× → `pressed` and `gate` stay 0. Then hold low for 6 cycles → `pressed`=1, and the next edge gives `gate`=1, `freq`=220<<FREQUENCY_FRACTIONAL_BITS, `step`=0.
- Held sequence: hold for 90 cycles after `gate` first rises → `gate` high for 6 cycles and low for 4, repeating. `freq` walks 220, 247 … 440 and then returns to 220 at the 9th note with `step`=0.
- Release mid-gate: release at cycle 3 of GATE_ON → `gate` falls one edge after `pressed` falls. `freq` keeps its value. A re-press restarts at `step`=0.
- Release in GATE_OFF: no further gate pulse occurs, and the state returns to IDLE.
- Parameter check: GATE_CYCLES=10, STEP_CYCLES=10 → elaboration error.

Source files
------------

// File: rtl/mypackage.sv
// Shared synth types and constants: oscillator frequency word, note table
// and the sequencer state encoding.
package mypackage;

    localparam int FREQUENCY_WIDTH           = 32;
    localparam int FREQUENCY_FRACTIONAL_BITS = 16;
    typedef logic [FREQUENCY_WIDTH-1:0] frequency;

    localparam int NOTE_COUNT = 8;
    localparam int NOTE_INDEX_WIDTH = $clog2(NOTE_COUNT);
    typedef logic [NOTE_INDEX_WIDTH-1:0] note_index;

    // A major scale, integer Hz
    localparam int NOTE_TABLE [NOTE_COUNT] = '{220, 247, 277, 294, 330, 370, 415, 440};

    typedef enum logic [1:0] {IDLE, GATE_ON, GATE_OFF} seq_state;

    function automatic frequency note_freq(input note_index idx);
        frequency hz;
        hz = frequency'(NOTE_TABLE[idx]);
        return hz << FREQUENCY_FRACTIONAL_BITS;
    endfunction

endpackage

// File: rtl/note_sequencer_debounce.sv
// Two-flop synchroniser plus persistence-count debouncer for the active-low
// trigger button; pressed is the inverted, registered stable level.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 1920
) (
    input  logic audio_clock,
    input  logic reset,
    input  logic key_n,
    output logic pressed
);

    localparam int COUNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);

    logic                   sync_1;
    logic                   sync_2;
    logic                   stable;
    logic [COUNT_WIDTH-1:0] count;

    always_ff @(posedge audio_clock or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            stable <= 1'b1;
            count  <= '0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            if (sync_2 == stable) begin
                count <= '0;
            end else if (count == COUNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                // level has differed for DEBOUNCE_CYCLES edges in a row
                stable <= ~stable;
                count  <= '0;
            end else begin
                count <= count + COUNT_WIDTH'(1);
            end
        end
    end

    assign pressed = ~stable;

endmodule

// File: rtl/note_sequencer.sv
// Steps through the note table while the debounced key is held, driving the
// oscillator frequency word and a timed gate pulse for the envelope.
module note_sequencer
    import mypackage::*;
#(
    parameter int DEBOUNCE_CYCLES = 1920,
    parameter int STEP_CYCLES     = 38400,
    parameter int GATE_CYCLES     = 28800
) (
    input  logic      audio_clock,
    input  logic      reset,
    input  logic      key_n,
    output logic      gate,
    output frequency  freq,
    output note_index step,
    output logic      pressed,
    output seq_state  state
);

    if (GATE_CYCLES < 1 || GATE_CYCLES >= STEP_CYCLES) begin : g_bad_timing
        $error("note_sequencer: need 1 <= GATE_CYCLES < STEP_CYCLES");
    end

    localparam int TIMER_WIDTH = $clog2(STEP_CYCLES);

    logic                   pressed_prev;
    logic [TIMER_WIDTH-1:0] timer;

    seq_state               state_d;
    logic                   gate_d;
    frequency               freq_d;
    note_index              step_d;
    note_index              next_step;
    logic [TIMER_WIDTH-1:0] timer_d;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .audio_clock (audio_clock),
        .reset       (reset),
        .key_n       (key_n),
        .pressed     (pressed)
    );

    always_ff @(posedge audio_clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            gate         <= 1'b0;
            freq         <= '0;
            step         <= '0;
            timer        <= '0;
            pressed_prev <= 1'b0;
        end else begin
            state        <= state_d;
            gate         <= gate_d;
            freq         <= freq_d;
            step         <= step_d;
            timer        <= timer_d;
            pressed_prev <= pressed;
        end
    end

    // Release is tested before timer expiry so it always wins.
    always_comb begin
        state_d   = state;
        gate_d    = gate;
        freq_d    = freq;
        step_d    = step;
        next_step = step + note_index'(1);
        timer_d   = timer + TIMER_WIDTH'(1);
        case (state)
            IDLE: begin
                gate_d  = 1'b0;
                timer_d = timer;
                if (pressed && !pressed_prev) begin
                    state_d = GATE_ON;
                    step_d  = '0;
                    freq_d  = note_freq('0);
                    gate_d  = 1'b1;
                    timer_d = '0;
                end
            end
            GATE_ON: begin
                if (!pressed) begin
                    gate_d  = 1'b0;
                    state_d = IDLE;
                end else if (timer == TIMER_WIDTH'(GATE_CYCLES - 1)) begin
                    gate_d  = 1'b0;
                    state_d = GATE_OFF;
                end
            end
            GATE_OFF: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (timer == TIMER_WIDTH'(STEP_CYCLES - 1)) begin
                    step_d  = next_step;
                    freq_d  = note_freq(next_step);
                    gate_d  = 1'b1;
                    timer_d = '0;
                    state_d = GATE_ON;
                end
            end
            default: begin
                gate_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule
